// File: rtl/test_pattern_gen.sv
// ---------------------------------------------------------------------------
// test_pattern_gen
//
// Purpose:
//   Generates video test patterns (colour bars, ramp, checkerboard, border)
//   on top of sync/active timing from an external video timing generator.
//   Sync and active are delayed so they stay aligned with the pixel data.
//   Every output is two pixel_clk cycles behind the timing inputs.
//
// Ports:
//   pixel_clk            pixel clock, all logic on its rising edge
//   resetn               asynchronous active-low reset
//   hsync_in, vsync_in   sync from the timing generator
//   active_in            active-video flag from the timing generator
//   auto_en              1 = cycle patterns automatically, 0 = use pat_sel
//   pat_sel[1:0]         manual pattern (0 BARS, 1 RAMP, 2 CHECKER, 3 BORDER)
//   pdata_r/g/b[7:0]     pixel data for the TMDS encoders (channels 2/1/0)
//   hsync_out, vsync_out, active_out
//                        sync/active aligned with pdata
//   pattern[1:0]         pattern currently displayed
// ---------------------------------------------------------------------------
module test_pattern_gen #(
  parameter int H_ACTIVE           = 1280,
  parameter int V_ACTIVE           = 720,
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic       pixel_clk,
  input  logic       resetn,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       active_in,
  input  logic       auto_en,
  input  logic [1:0] pat_sel,
  output logic [7:0] pdata_r,
  output logic [7:0] pdata_g,
  output logic [7:0] pdata_b,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       active_out,
  output logic [1:0] pattern
);

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    RAMP    = 2'd1,
    CHECKER = 2'd2,
    BORDER  = 2'd3
  } pattern_t;

  localparam int          BAR_W      = H_ACTIVE / 8;
  localparam logic [10:0] X_LAST     = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_LAST     = 10'(V_ACTIVE - 1);
  localparam logic [10:0] BAR_LAST   = 11'(BAR_W - 1);
  localparam logic [7:0]  FRAME_LAST = 8'(FRAMES_PER_PATTERN - 1);

  logic [10:0] x;
  logic [9:0]  y;
  logic [10:0] bar_sub;
  logic [2:0]  bar_idx;
  logic [7:0]  frame_cnt;
  pattern_t    pat_q;

  // first pipeline stage; act_s1/vs_s1 double as the registered copies
  // used for edge detection
  logic        act_s1;
  logic        hs_s1;
  logic        vs_s1;
  logic [23:0] rgb_s1;
  logic [1:0]  pat_s1;

  logic [23:0] pix_rgb;
  logic        line_end;
  logic        frame_start;

  // active falling edge ends a line; vsync rising edge is the sole frame boundary
  assign line_end    = act_s1 & ~active_in;
  assign frame_start = vsync_in & ~vs_s1;

  // Pixel, bar and line counters. The bar index is tracked with its own
  // sub-counter so no divider is needed to find which bar x falls in.
  always_ff @(posedge pixel_clk or negedge resetn) begin
    if (!resetn) begin
      x       <= '0;
      y       <= '0;
      bar_sub <= '0;
      bar_idx <= '0;
    end else begin
      if (active_in) begin
        if (x != X_LAST) x <= x + 11'd1;
        if (bar_sub == BAR_LAST) begin
          bar_sub <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_sub <= bar_sub + 11'd1;
        end
      end else if (line_end) begin
        x       <= '0;
        bar_sub <= '0;
        bar_idx <= '0;
      end

      if (frame_start)
        y <= '0;
      else if (line_end && (y != Y_LAST))
        y <= y + 10'd1;
    end
  end

  // Frame counter and pattern selection. The pattern only changes on a
  // frame boundary so a frame is never split between two patterns. In
  // manual mode the frame counter is pinned at 0, so switching back to
  // auto starts a fresh dwell period from the current pattern.
  always_ff @(posedge pixel_clk or negedge resetn) begin
    if (!resetn) begin
      frame_cnt <= '0;
      pat_q     <= BARS;
    end else if (!auto_en) begin
      frame_cnt <= '0;
      if (frame_start) pat_q <= pattern_t'(pat_sel);
    end else if (frame_start) begin
      if (frame_cnt >= FRAME_LAST) begin
        frame_cnt <= '0;
        pat_q     <= pattern_t'(pat_q + 2'd1);
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Colour for the current pixel, packed as {r, g, b}.
  always_comb begin
    pix_rgb = 24'h000000;
    case (pat_q)
      BARS: begin
        case (bar_idx)
          3'd0:    pix_rgb = 24'hFFFFFF;
          3'd1:    pix_rgb = 24'hFFFF00;
          3'd2:    pix_rgb = 24'h00FFFF;
          3'd3:    pix_rgb = 24'h00FF00;
          3'd4:    pix_rgb = 24'hFF00FF;
          3'd5:    pix_rgb = 24'hFF0000;
          3'd6:    pix_rgb = 24'h0000FF;
          default: pix_rgb = 24'h000000;
        endcase
      end
      RAMP:    pix_rgb = {x[7:0], x[7:0], x[7:0]};
      CHECKER: if (x[5] ^ y[5]) pix_rgb = 24'hFFFFFF;
      BORDER:  if ((x == 11'd0) || (x == X_LAST) || (y == 10'd0) || (y == Y_LAST))
                 pix_rgb = 24'hFFFFFF;
      default: pix_rgb = 24'h000000;
    endcase
  end

  // Two-stage output pipeline. Colour is blanked in the first stage so the
  // data leaving the block is zero whenever the aligned active flag is low.
  always_ff @(posedge pixel_clk or negedge resetn) begin
    if (!resetn) begin
      act_s1     <= 1'b0;
      hs_s1      <= 1'b0;
      vs_s1      <= 1'b0;
      rgb_s1     <= '0;
      pat_s1     <= '0;
      active_out <= 1'b0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      pdata_r    <= '0;
      pdata_g    <= '0;
      pdata_b    <= '0;
      pattern    <= '0;
    end else begin
      act_s1     <= active_in;
      hs_s1      <= hsync_in;
      vs_s1      <= vsync_in;
      rgb_s1     <= active_in ? pix_rgb : 24'h000000;
      pat_s1     <= pat_q;
      active_out <= act_s1;
      hsync_out  <= hs_s1;
      vsync_out  <= vs_s1;
      pdata_r    <= rgb_s1[23:16];
      pdata_g    <= rgb_s1[15:8];
      pdata_b    <= rgb_s1[7:0];
      pattern    <= pat_s1;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_test_pattern_gen
//
// Self-checking bench for test_pattern_gen, run with a reduced 256x64
// raster and a 2-frame pattern dwell. Every driven cycle pushes its
// expected output (from a reference model of the pattern rules) to a
// queue; the entry is popped and compared two clocks later.
// ---------------------------------------------------------------------------
module tb_test_pattern_gen;

  localparam int H   = 256;
  localparam int V   = 64;
  localparam int FPP = 2;

  logic       pixel_clk = 1'b0;
  logic       resetn;
  logic       hsync_in;
  logic       vsync_in;
  logic       active_in;
  logic       auto_en;
  logic [1:0] pat_sel;
  logic [7:0] pdata_r;
  logic [7:0] pdata_g;
  logic [7:0] pdata_b;
  logic       hsync_out;
  logic       vsync_out;
  logic       active_out;
  logic [1:0] pattern;

  typedef struct packed {
    logic        act;
    logic        hs;
    logic        vs;
    logic [1:0]  pat;
    logic [23:0] rgb;
  } vec_t;

  vec_t sb[$];
  vec_t expv;
  vec_t gotv;
  bit   have;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  int         mx;
  int         my;
  int         mframe;
  logic [1:0] mpat;
  logic       prev_act;
  logic       prev_vs;

  test_pattern_gen #(
    .H_ACTIVE          (H),
    .V_ACTIVE          (V),
    .FRAMES_PER_PATTERN(FPP)
  ) dut (
    .pixel_clk (pixel_clk),
    .resetn    (resetn),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .active_in (active_in),
    .auto_en   (auto_en),
    .pat_sel   (pat_sel),
    .pdata_r   (pdata_r),
    .pdata_g   (pdata_g),
    .pdata_b   (pdata_b),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .active_out(active_out),
    .pattern   (pattern)
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic vec_t observed();
    return vec_t'({active_out, hsync_out, vsync_out, pattern, pdata_r, pdata_g, pdata_b});
  endfunction

  // Reference colour for pattern p at pixel (x, y).
  function automatic logic [23:0] model_rgb(input logic [1:0] p, input int x, input int y);
    logic [23:0] c;
    logic [7:0]  v;
    c = 24'h000000;
    case (p)
      2'd0: begin
        case (x / (H / 8))
          0: c = 24'hFFFFFF;
          1: c = 24'hFFFF00;
          2: c = 24'h00FFFF;
          3: c = 24'h00FF00;
          4: c = 24'hFF00FF;
          5: c = 24'hFF0000;
          6: c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      2'd1: begin
        v = 8'(x % 256);
        c = {v, v, v};
      end
      2'd2: if ((((x >> 5) & 1) ^ ((y >> 5) & 1)) == 1) c = 24'hFFFFFF;
      default: if (x == 0 || x == H - 1 || y == 0 || y == V - 1) c = 24'hFFFFFF;
    endcase
    return c;
  endfunction

  // Input waveform of one frame: nl lines of np active pixels plus 8 blank
  // cycles (hsync in the blank), then a 6-cycle vsync postlude.
  function automatic void frame_cycle(input int c, input int nl, input int np,
                                      output logic act, output logic hs, output logic vs);
    int per;
    int body;
    int col;
    per  = np + 8;
    body = nl * per;
    act  = 1'b0;
    hs   = 1'b0;
    vs   = 1'b0;
    if (c < body) begin
      col = c % per;
      act = (col < np);
      hs  = (col >= np + 2) && (col < np + 5);
    end else begin
      vs = (c - body >= 1) && (c - body <= 3);
    end
  endfunction

  task automatic model_reset();
    mx       = 0;
    my       = 0;
    mframe   = 0;
    mpat     = 2'd0;
    prev_act = 1'b0;
    prev_vs  = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle, push its expectation, advance the model and the clock,
  // and hand back the entry whose result is now on the outputs (if any).
  task automatic step(input logic act, input logic hs, input logic vs,
                      output bit h, output vec_t e, output vec_t g);
    vec_t n;
    active_in = act;
    hsync_in  = hs;
    vsync_in  = vs;
    n.act = act;
    n.hs  = hs;
    n.vs  = vs;
    n.pat = mpat;
    n.rgb = act ? model_rgb(mpat, mx, my) : 24'h000000;
    sb.push_back(n);

    if (vs && !prev_vs) begin
      my = 0;
      if (!auto_en) begin
        mpat = pat_sel;
      end else if (mframe == FPP - 1) begin
        mframe = 0;
        mpat   = mpat + 2'd1;
      end else begin
        mframe++;
      end
    end else if (prev_act && !act && my < V - 1) begin
      my++;
    end
    if (!auto_en) mframe = 0;
    if (act) begin
      if (mx < H - 1) mx++;
    end else if (prev_act) begin
      mx = 0;
    end
    prev_act = act;
    prev_vs  = vs;

    @(posedge pixel_clk);
    #1;
    h = 1'b0;
    e = '0;
    g = '0;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      g = observed();
      h = 1'b1;
    end
  endtask

  task automatic applyStimulus_idle();
    active_in = 1'b0;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    active_in = 1'b1;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    auto_en   = 1'b1;
    pat_sel   = 2'd3;
    repeat (3) @(posedge pixel_clk);
    #1;
    vectors++;
    if (observed() !== vec_t'('0)) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0", observed());
    end
    applyStimulus_idle();
    model_reset();
    resetn = 1'b1;
    @(posedge pixel_clk);
    #1;
    vectors++;
    if (pattern !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_pattern: got %0d, expected 0", pattern);
    end
  endtask

  task automatic test_latency();
    for (int c = 0; c < 10; c++) begin
      step(c == 3, (c >= 3 && c <= 5), 1'b0, have, expv, gotv);
      if (have) begin
        vectors++;
        if (gotv !== expv) begin
          miscompares++;
          $display("[TB] FAIL latency_vec c=%0d: got %h, expected %h", c, gotv, expv);
        end
      end
      vectors++;
      if (active_out !== (c == 4)) begin
        miscompares++;
        $display("[TB] FAIL latency_active c=%0d: got %b, expected %b", c, active_out, (c == 4));
      end
    end
  endtask

  task automatic test_bars();
    logic a, hs, vs;
    auto_en = 1'b0;
    pat_sel = 2'd0;
    for (int c = 0; c < (H + 8) + 6; c++) begin
      frame_cycle(c, 1, H, a, hs, vs);
      step(a, hs, vs, have, expv, gotv);
      if (have) begin
        vectors++;
        if (gotv !== expv) begin
          miscompares++;
          $display("[TB] FAIL bars c=%0d: got %h, expected %h", c, gotv, expv);
        end
      end
    end
  endtask

  task automatic test_manual();
    logic a, hs, vs;
    int   nl[3] = '{0, 3, 1};
    int   want[3] = '{0, 1, 3};
    int   body;
    auto_en = 1'b0;
    pat_sel = 2'd1;
    for (int f = 0; f < 3; f++) begin
      body = nl[f] * (16 + 8);
      for (int c = 0; c < body + 6; c++) begin
        if (f == 1 && c == 24 + 8) pat_sel = 2'd3;
        frame_cycle(c, nl[f], 16, a, hs, vs);
        step(a, hs, vs, have, expv, gotv);
        if (have) begin
          vectors++;
          if (gotv !== expv) begin
            miscompares++;
            $display("[TB] FAIL manual f=%0d c=%0d: got %h, expected %h", f, c, gotv, expv);
          end
        end
        if (nl[f] > 0 && c == body - 1) begin
          vectors++;
          if (pattern !== 2'(want[f])) begin
            miscompares++;
            $display("[TB] FAIL manual_pattern f=%0d: got %0d, expected %0d", f, pattern, want[f]);
          end
        end
      end
    end
  endtask

  task automatic test_border_checker();
    logic        a, hs, vs;
    int          nl[3] = '{0, V, 33};
    int          per;
    int          body;
    int          d;
    int          line;
    int          col;
    bit          spot;
    logic [23:0] spot_rgb;
    auto_en = 1'b0;
    pat_sel = 2'd3;
    per = H + 8;
    for (int f = 0; f < 3; f++) begin
      body = nl[f] * per;
      for (int c = 0; c < body + 6; c++) begin
        if (f == 1 && c == body) pat_sel = 2'd2;
        frame_cycle(c, nl[f], H, a, hs, vs);
        step(a, hs, vs, have, expv, gotv);
        if (have) begin
          vectors++;
          if (gotv !== expv) begin
            miscompares++;
            $display("[TB] FAIL border_checker f=%0d c=%0d: got %h, expected %h", f, c, gotv, expv);
          end
          d        = c - 1;
          spot     = 1'b0;
          spot_rgb = 24'h000000;
          if (d >= 0 && d < body) begin
            line = d / per;
            col  = d % per;
            if (f == 1) begin
              if (line == 0 && col == 5)           begin spot = 1'b1; spot_rgb = 24'hFFFFFF; end
              if (line == 5 && col == 5)           begin spot = 1'b1; spot_rgb = 24'h000000; end
              if (line == 5 && col == H - 1)       begin spot = 1'b1; spot_rgb = 24'hFFFFFF; end
              if (line == 5 && col == 0)           begin spot = 1'b1; spot_rgb = 24'hFFFFFF; end
              if (line == V - 1 && col == 100)     begin spot = 1'b1; spot_rgb = 24'hFFFFFF; end
            end else if (f == 2) begin
              if (line == 0 && col == 32)          begin spot = 1'b1; spot_rgb = 24'hFFFFFF; end
              if (line == 0 && col == 31)          begin spot = 1'b1; spot_rgb = 24'h000000; end
              if (line == 32 && col == 32)         begin spot = 1'b1; spot_rgb = 24'h000000; end
              if (line == 32 && col == 0)          begin spot = 1'b1; spot_rgb = 24'hFFFFFF; end
            end
          end
          if (spot) begin
            vectors++;
            if (gotv.rgb !== spot_rgb) begin
              miscompares++;
              $display("[TB] FAIL pixel_spot f=%0d (%0d,%0d): got %h, expected %h",
                       f, col, line, gotv.rgb, spot_rgb);
            end
          end
        end
      end
    end
  endtask

  task automatic test_auto_cycle();
    logic a, hs, vs;
    int   want[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int   body;
    auto_en = 1'b1;
    applyStimulus_idle();
    resetn = 1'b0;
    model_reset();
    @(posedge pixel_clk);
    #1;
    resetn = 1'b1;
    body = 2 * (16 + 8);
    for (int f = 0; f < 9; f++) begin
      for (int c = 0; c < body + 6; c++) begin
        frame_cycle(c, 2, 16, a, hs, vs);
        step(a, hs, vs, have, expv, gotv);
        if (have) begin
          vectors++;
          if (gotv !== expv) begin
            miscompares++;
            $display("[TB] FAIL auto f=%0d c=%0d: got %h, expected %h", f, c, gotv, expv);
          end
        end
        if (c == body - 1) begin
          vectors++;
          if (pattern !== 2'(want[f])) begin
            miscompares++;
            $display("[TB] FAIL auto_pattern f=%0d: got %0d, expected %0d", f, pattern, want[f]);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic a, hs, vs;
    auto_en = 1'b0;
    pat_sel = 2'd3;
    for (int c = 0; c < 6 + 20; c++) begin
      if (c < 6) frame_cycle(c, 0, H, a, hs, vs);
      else begin a = 1'b1; hs = 1'b0; vs = 1'b0; end
      step(a, hs, vs, have, expv, gotv);
      if (have) begin
        vectors++;
        if (gotv !== expv) begin
          miscompares++;
          $display("[TB] FAIL pre_reset c=%0d: got %h, expected %h", c, gotv, expv);
        end
      end
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if (observed() !== vec_t'('0)) begin
      miscompares++;
      $display("[TB] FAIL midline_reset: got %h, expected 0", observed());
    end
    model_reset();
    @(posedge pixel_clk);
    #1;
    auto_en = 1'b1;
    resetn  = 1'b1;
    for (int c = 0; c < 40 + 8; c++) begin
      step(c < 40, 1'b0, 1'b0, have, expv, gotv);
      if (have) begin
        vectors++;
        if (gotv !== expv) begin
          miscompares++;
          $display("[TB] FAIL post_reset c=%0d: got %h, expected %h", c, gotv, expv);
        end
      end
    end
    vectors++;
    if (pattern !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_pattern: got %0d, expected 0", pattern);
    end
  endtask

  task automatic checkOutput_summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bars();
    test_manual();
    test_border_checker();
    test_auto_cycle();
    test_mid_reset();
    checkOutput_summary();
    $finish;
  end

endmodule

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, 720, active lines per frame.
REQ-003 SHALL have parameter FRAMES_PER_PATTERN, 120, frames each pattern is shown in auto mode (2 s at 60 fps).
REQ-004 SHALL use one clock and an asynchronous, active-low reset, named pixel_clk and resetn.
REQ-005 SHALL have port pixel_clk, input, 1, pixel clock; all logic on its rising edge.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port hsync_in, input, 1, horizontal sync from the video timing generator.
REQ-008 SHALL have port vsync_in, input, 1, vertical sync from the video timing generator.
REQ-009 SHALL have port active_in, input, 1, active-video flag from the video timing generator.
REQ-010 SHALL have port auto_en, input, 1: 1 = cycle patterns automatically; 0 = use pat_sel.
REQ-011 SHALL have port pat_sel, input, 2, manual pattern: 0 BARS, 1 RAMP, 2 CHECKER, 3 BORDER.
REQ-012 SHALL have port pdata_r / pdata_g / pdata_b, output, 8 each, pixel data to the TMDS encoders (channels 2/1/0).
REQ-013 SHALL have port hsync_out, vsync_out, active_out, output, 1 each, sync/active delayed to align with pdata.
REQ-014 SHALL have port pattern, output, 2, pattern currently displayed.

Function
REQ-015 SHALL register all outputs with a fixed latency of 2 pixel_clk cycles from hsync_in/vsync_in/active_in to every output.
REQ-016 SHALL keep pixel counter x (11 bit): +1 per active_in=1 cycle; cleared on the cycle after active_in falls; saturates at H_ACTIVE-1.
REQ-017 SHALL keep line counter y (10 bit): +1 on each active_in falling edge; cleared on vsync_in rising edge; saturates at V_ACTIVE-1.
REQ-018 SHALL detect vsync_in rising edge from a registered copy; this edge is the only frame boundary.
REQ-019 SHALL keep frame counter (8 bit): +1 per frame boundary; wraps to 0 after FRAMES_PER_PATTERN-1.
REQ-020 SHALL update pattern only at a frame boundary, never mid-frame.
REQ-021 SHALL, auto_en=1, advance pattern BARS->RAMP->CHECKER->BORDER->BARS at the boundary where frame counter wraps.
REQ-022 SHALL, auto_en=0, load pattern from pat_sel at every frame boundary and hold frame counter at 0.
REQ-023 SHALL, on auto_en 0->1, continue cycling from the current pattern with frame counter starting at 0.
REQ-024 SHALL drive pdata_r/g/b = 0 whenever the aligned active_out = 0.
REQ-025 BARS: 8 vertical bars, each H_ACTIVE/8 px, left to right white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00); bar index from a bar counter and sub-counter, no divider.
REQ-026 RAMP: all three channels = x[7:0] (wraps every 256 px).
REQ-027 CHECKER: white (0xFF all) when x[5] XOR y[5] = 1, else black.
REQ-028 BORDER: white when x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1; black elsewhere.
REQ-029 SHALL pass hsync_in/vsync_in through the same 2-stage delay regardless of pattern.

Reset
REQ-030 SHALL, while resetn=0, asynchronously clear x, y, frame counter, bar counters, edge registers and delay pipes; pattern=BARS; all outputs 0.
REQ-031 SHALL, on reset release mid-frame, count from x=0, y=0; pattern stays BARS until the first frame boundary.

Verification
REQ-032 Reset: resetn=0 mid-line with active_in=1 -> all outputs 0 same cycle; after release with auto_en=1, pattern=0.
REQ-033 Latency: single active_in pulse at cycle N -> active_out high at N+2 only; hsync_in toggled at N -> hsync_out at N+2.
REQ-034 Bars: BARS, full 1280-px line -> x=0..159 give FF/FF/FF; x=160 gives FF/FF/00; x=1120..1279 give 00/00/00.
REQ-035 Auto cycle: auto_en=1, FRAMES_PER_PATTERN=2, 9 frames -> pattern 0,0,1,1,2,2,3,3,0 per frame.
REQ-036 Manual: auto_en=0, pat_sel 1->3 mid-frame -> pattern stays 1 until next vsync_in rise, then 3.
REQ-037 Border/checker: BORDER, 1280x720 frame -> only row 0, row 719, column 0, column 1279 white; CHECKER pixel (32,0) white, (32,32) black.
